sample_frame_merge: RTL and testbench

- Parametrised successor to the fixed 4-way valid/ready merge between the I2S receivers and the ANC core.
- Per-channel buffering, runtime channel enables, and an optional timeout mode that emits a frame when some channels are late instead of stalling.
- Sits between N i2s_rx instances and anc_top; delivers one aligned multi-channel frame per handshake.

---
 rtl/sfm_pkg.sv | 19 +
 rtl/sfm_chan_fifo.sv | 45 ++++
 rtl/sample_frame_merge.sv | 153 +++++++++++++++
 tb/tb_sample_frame_merge.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfm_pkg.sv
// Shared constants and helpers for the sample frame merge block.
// Holds default sizing, the mode encoding and the packed-lane slice helper.
// No logic of its own; imported by the merge top and its channel FIFO.
package sfm_pkg;

   localparam int NCH_DEF   = 4;
   localparam int DW_DEF    = 16;
   localparam int DEPTH_DEF = 4;
   localparam int TW_DEF    = 12;

   localparam logic MODE_LOCKSTEP = 1'b0;
   localparam logic MODE_TIMEOUT  = 1'b1;

   // LSB position of channel ch inside a packed NCH*DW bus
   function automatic int lane_lsb(input int ch, input int dw);
      return ch * dw;
   endfunction

endpackage

// File: rtl/sfm_chan_fifo.sv
// Per-channel synchronous FIFO holding samples until a frame launch pops them.
// Latency: a push at edge N is visible on head/empty after edge N; pop is same-cycle head read.
// Backpressure: full is exported; the caller gates push (a pop in the same cycle frees a slot).
module sfm_chan_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [DW-1:0] wr_data,
   output logic          full,
   output logic          empty,
   output logic [DW-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [DW-1:0] mem [DEPTH];

   // pointer update; the extra MSB tells a full FIFO from an empty one
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // sample storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sample_frame_merge.sv
// Merges NCH buffered sample streams into aligned frames, with optional timeout fill from hold values.
// Latency: sample written at edge N is on out_data after edge N+1; timeout launch when the counter hits timeout_cycles.
// Backpressure: output register stalls on !out_rdy; enabled channels deassert in_rdy when their FIFO is full.
module sample_frame_merge
   import sfm_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int TW    = TW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    ch_en,
   input  logic              mode,
   input  logic [TW-1:0]     timeout_cycles,
   input  logic [NCH-1:0]    in_vld,
   output logic [NCH-1:0]    in_rdy,
   input  logic [NCH*DW-1:0] in_data,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [NCH*DW-1:0] out_data,
   output logic [NCH-1:0]    out_stale,
   input  logic              clr_status,
   output logic [NCH-1:0]    ovf
);

   logic [NCH-1:0]    fifo_full;
   logic [NCH-1:0]    fifo_empty;
   logic [NCH-1:0]    fifo_push;
   logic [NCH-1:0]    fifo_pop;
   logic [NCH-1:0]    fifo_flush;
   logic [NCH-1:0]    ne;
   logic [DW-1:0]     fifo_head [NCH];
   logic [DW-1:0]     hold_q    [NCH];
   logic [TW-1:0]     cnt_q;
   logic [NCH*DW-1:0] frame_dat;
   logic [NCH-1:0]    frame_stale;
   logic              ld_ok;
   logic              any_en;
   logic              any_ne;
   logic              l1;
   logic              l2;
   logic              launch;

   // launch decision: all enabled channels present, or timeout reached with partial data
   always_comb begin
      ld_ok  = !out_vld || out_rdy;
      ne     = ch_en & ~fifo_empty;
      any_en = |ch_en;
      any_ne = |ne;
      l1     = any_en && ((ne | ~ch_en) == '1);
      l2     = (mode == MODE_TIMEOUT) && (timeout_cycles != '0) && any_ne
               && (cnt_q == timeout_cycles);
      launch = ld_ok && (l1 || l2);
   end

   // input handshakes; a disabled channel swallows data and keeps its FIFO flushed
   always_comb begin
      in_rdy     = '0;
      fifo_push  = '0;
      fifo_pop   = '0;
      fifo_flush = '0;
      for (int i = 0; i < NCH; i++) begin
         fifo_pop[i]   = launch && ne[i];
         fifo_flush[i] = !ch_en[i];
         if (rst)
            in_rdy[i] = 1'b0;
         else if (ch_en[i])
            in_rdy[i] = !fifo_full[i] || fifo_pop[i];
         else
            in_rdy[i] = 1'b1;
         fifo_push[i] = in_vld[i] && in_rdy[i] && ch_en[i];
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      sfm_chan_fifo #(
         .DW    (DW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push    (fifo_push[g]),
         .pop     (fifo_pop[g]),
         .flush   (fifo_flush[g]),
         .wr_data (in_data[lane_lsb(g, DW) +: DW]),
         .full    (fifo_full[g]),
         .empty   (fifo_empty[g]),
         .head    (fifo_head[g])
      );
   end

   // frame assembly: fresh head, repeated hold for late enabled lanes, zero for disabled
   always_comb begin
      frame_dat   = '0;
      frame_stale = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ne[i]) begin
            frame_dat[lane_lsb(i, DW) +: DW] = fifo_head[i];
         end else if (ch_en[i]) begin
            frame_dat[lane_lsb(i, DW) +: DW] = hold_q[i];
            frame_stale[i] = 1'b1;
         end
      end
   end

   // hold registers track the last real sample popped per channel
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (rst)
            hold_q[i] <= '0;
         else if (fifo_pop[i])
            hold_q[i] <= fifo_head[i];
      end
   end

   // output register: loads on launch, drops valid once consumed with nothing new
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld   <= 1'b0;
         out_data  <= '0;
         out_stale <= '0;
      end else if (launch) begin
         out_vld   <= 1'b1;
         out_data  <= frame_dat;
         out_stale <= frame_stale;
      end else if (out_rdy) begin
         out_vld   <= 1'b0;
      end
   end

   // timeout counter: frozen while stalled, saturates at timeout_cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (ld_ok) begin
         if (launch || !any_ne)
            cnt_q <= '0;
         else if (!l1 && (cnt_q < timeout_cycles))
            cnt_q <= cnt_q + TW'(1);
      end
   end

   // sticky overflow; a new hit in the clear cycle still sets the bit
   always_ff @(posedge clk) begin
      if (rst)
         ovf <= '0;
      else
         ovf <= (clr_status ? '0 : ovf) | (in_vld & fifo_full & ch_en);
   end

endmodule

// File: tb/tb_sample_frame_merge.sv
// Self-checking bench for sample_frame_merge with a queue-based reference model.
// Inputs change at the falling edge; outputs are compared 1 time unit later.
// Directed scenarios first, then a randomized soak, then a mid-run reset.
module tb_sample_frame_merge;

   localparam int NCH   = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int TW    = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    ch_en;
   logic              mode;
   logic [TW-1:0]     timeout_cycles;
   logic [NCH-1:0]    in_vld;
   logic [NCH-1:0]    in_rdy;
   logic [NCH*DW-1:0] in_data;
   logic              out_vld;
   logic              out_rdy;
   logic [NCH*DW-1:0] out_data;
   logic [NCH-1:0]    out_stale;
   logic              clr_status;
   logic [NCH-1:0]    ovf;

   always #5 clk = ~clk;

   sample_frame_merge #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .TW(TW)) dut (
      .clk            (clk),
      .rst            (rst),
      .ch_en          (ch_en),
      .mode           (mode),
      .timeout_cycles (timeout_cycles),
      .in_vld         (in_vld),
      .in_rdy         (in_rdy),
      .in_data        (in_data),
      .out_vld        (out_vld),
      .out_rdy        (out_rdy),
      .out_data       (out_data),
      .out_stale      (out_stale),
      .clr_status     (clr_status),
      .ovf            (ovf)
   );

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [DW-1:0]     mq [NCH][$];
   logic [DW-1:0]     m_hold [NCH];
   int                m_cnt = 0;
   logic              m_vld = 1'b0;
   logic [NCH*DW-1:0] m_data = '0;
   logic [NCH-1:0]    m_stale = '0;
   logic [NCH-1:0]    m_ovf = '0;
   logic [NCH-1:0]    last_rdy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // compare DUT against model for the current cycle, then advance both by one edge
   task automatic tick();
      logic [NCH-1:0] full, ne, rdy;
      logic any_en, any_ne, l1, l2, ld, launch;
      logic [DW-1:0] v;
      #1;
      chk("out_vld", out_vld, m_vld);
      if (m_vld) begin
         chk("out_data", out_data, m_data);
         chk("out_stale", out_stale, m_stale);
      end
      chk("ovf", ovf, m_ovf);
      last_rdy = in_rdy;
      if (rst) begin
         chk("in_rdy_rst", in_rdy, '0);
         for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            m_hold[i] = '0;
         end
         m_cnt = 0; m_vld = 0; m_data = '0; m_stale = '0; m_ovf = '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            full[i] = (mq[i].size() == DEPTH);
            ne[i]   = ch_en[i] && (mq[i].size() != 0);
         end
         any_en = |ch_en;
         any_ne = |ne;
         l1 = any_en;
         for (int i = 0; i < NCH; i++)
            if (ch_en[i] && mq[i].size() == 0) l1 = 1'b0;
         l2 = mode && (timeout_cycles != 0) && any_ne && (m_cnt == int'(timeout_cycles));
         ld = !m_vld || out_rdy;
         launch = ld && (l1 || l2);
         for (int i = 0; i < NCH; i++)
            rdy[i] = ch_en[i] ? (!full[i] || (launch && ne[i])) : 1'b1;
         chk("in_rdy", in_rdy, rdy);
         m_ovf = (clr_status ? '0 : m_ovf) | (in_vld & full & ch_en);
         if (ld) begin
            if (launch || !any_ne) m_cnt = 0;
            else if (!l1 && m_cnt < int'(timeout_cycles)) m_cnt++;
         end
         if (launch) begin
            m_vld = 1'b1;
            for (int i = 0; i < NCH; i++) begin
               if (ne[i]) begin
                  v = mq[i].pop_front();
                  m_hold[i] = v;
                  m_data[i*DW +: DW] = v;
                  m_stale[i] = 1'b0;
               end else if (ch_en[i]) begin
                  m_data[i*DW +: DW] = m_hold[i];
                  m_stale[i] = 1'b1;
               end else begin
                  m_data[i*DW +: DW] = '0;
                  m_stale[i] = 1'b0;
               end
            end
         end else if (out_rdy) begin
            m_vld = 1'b0;
         end
         for (int i = 0; i < NCH; i++) begin
            if (!ch_en[i]) mq[i].delete();
            else if (in_vld[i] && rdy[i]) mq[i].push_back(in_data[i*DW +: DW]);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_data();
      for (int i = 0; i < NCH; i++) in_data[i*DW +: DW] = DW'($urandom);
   endtask

   initial begin
      int first, nfr, lat, acc0, hs;
      logic [NCH*DW-1:0] saved;
      logic [DW-1:0] exp0 [$];
      for (int i = 0; i < NCH; i++) m_hold[i] = '0;
      rst = 1'b1; ch_en = '1; mode = 1'b0; timeout_cycles = '0;
      in_vld = '0; in_data = '0; out_rdy = 1'b1; clr_status = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tick();
      chk("rst_vld", out_vld, 0);
      chk("rst_data", out_data, 0);
      chk("rst_stale", out_stale, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b0;

      // lockstep: one aligned push, frame one edge later
      in_data = 64'h0004_0003_0002_0001; in_vld = '1;
      tick();
      in_vld = '0;
      chk("t1_vld_early", out_vld, 0);
      tick();
      chk("t1_vld", out_vld, 1);
      chk("t1_data", out_data, 64'h0004_0003_0002_0001);
      chk("t1_stale", out_stale, 0);
      tick();

      // skew: ch3 arrives at cycle 10, frame must wait for it
      first = -1; nfr = 0;
      for (int c = 0; c <= 13; c++) begin
         rand_data();
         in_vld = (c == 0) ? 4'b0111 : (c == 10) ? 4'b1000 : 4'b0000;
         tick();
         if (out_vld) begin
            nfr++;
            if (first < 0) first = c;
         end
      end
      chk("t2_first_edge", first, 11);
      chk("t2_frames", nfr, 1);
      chk("t2_fifo_empty", dut.fifo_empty, 4'hF);

      // timeout fill: prime ch3 hold with 0x7FFF, then leave ch3 silent
      mode = 1'b1; timeout_cycles = 12'd5;
      rand_data(); in_data[63:48] = 16'h7FFF; in_vld = '1;
      tick();
      in_vld = '0;
      tick(); tick();
      rand_data(); saved = in_data; in_vld = 4'b0111;
      tick();
      in_vld = '0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (out_vld) begin lat = k; break; end
      end
      // counter reaches 5 five edges after the write; the launch edge follows
      chk("t3_latency", lat, 6);
      chk("t3_lane3", out_data[63:48], 16'h7FFF);
      chk("t3_lanes012", out_data[47:0], saved[47:0]);
      chk("t3_stale", out_stale, 4'b1000);
      tick();
      mode = 1'b0; timeout_cycles = '0;

      // backpressure: consumer stalled for 12 cycles under continuous input
      out_rdy = 1'b0; in_vld = '1; acc0 = 0; saved = '0;
      for (int c = 0; c < 12; c++) begin
         rand_data();
         tick();
         if (last_rdy[0]) begin
            acc0++;
            exp0.push_back(in_data[15:0]);
         end
         if (out_vld && c > 1) chk("t4_stable", out_data, saved);
         if (out_vld) saved = out_data;
      end
      chk("t4_accepted", acc0, 5);
      chk("t4_ovf", ovf, 4'hF);
      in_vld = '0; out_rdy = 1'b1; hs = 0;
      for (int c = 0; c < 8; c++) begin
         if (out_vld) begin
            hs++;
            if (exp0.size() > 0) chk("t4_order", out_data[15:0], exp0.pop_front());
            else chk("t4_order_extra", out_data[15:0], 64'hx);
         end
         tick();
      end
      chk("t4_frames", hs, 5);
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      chk("t4_ovf_clr", ovf, 0);

      // enable change: ch2 holds two samples when it is disabled
      rand_data(); in_vld = 4'b0100;
      tick(); rand_data(); tick();
      in_vld = '0;
      chk("t5_ch2_pending", dut.fifo_empty[2], 0);
      ch_en = 4'b1011; rand_data(); in_vld = 4'b0100;
      tick();
      chk("t5_rdy2", last_rdy[2], 1);
      chk("t5_flushed", dut.fifo_empty[2], 1);
      rand_data(); in_vld = 4'b1111;
      tick();
      in_vld = '0;
      tick();
      chk("t5_vld", out_vld, 1);
      chk("t5_lane2", out_data[47:32], 0);
      chk("t5_stale", out_stale, 0);
      ch_en = '1;
      tick();

      // randomized soak against the model
      for (int c = 0; c < 600; c++) begin
         if (c % 60 == 0) begin
            mode = 1'($urandom);
            timeout_cycles = TW'($urandom_range(0, 6));
            ch_en = ($urandom % 3 == 0) ? NCH'($urandom) : '1;
         end
         if ($urandom % 40 == 0) ch_en = NCH'($urandom);
         rand_data();
         in_vld = NCH'($urandom);
         out_rdy = ($urandom % 4) != 0;
         clr_status = ($urandom % 16) == 0;
         tick();
      end
      clr_status = 1'b0;

      // reset in the middle of traffic
      ch_en = '1; mode = 1'b0; timeout_cycles = '0; out_rdy = 1'b0;
      rand_data(); in_vld = '1;
      tick(); rand_data(); tick(); rand_data(); tick();
      in_vld = '0;
      chk("t7_pre_vld", out_vld, 1);
      rst = 1'b1;
      tick();
      chk("t7_vld", out_vld, 0);
      chk("t7_data", out_data, 0);
      chk("t7_ovf", ovf, 0);
      chk("t7_stale", out_stale, 0);
      rst = 1'b0; mode = 1'b1; timeout_cycles = 12'd1; out_rdy = 1'b1;
      nfr = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (out_vld) nfr++;
      end
      chk("t7_no_launch", nfr, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
